// File: rtl/condlogic_pkg.sv
// Shared controller definitions: condition-code encodings and NZCV bit positions.
package condlogic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// Combinational evaluation of a 4-bit condition field against the NZCV flags.
module condlogic_condcheck
    import condlogic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            // The reserved encoding executes unconditionally.
            COND_NV: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Condition stage: holds NZCV, samples the condition once per instruction in decode,
// and gates the decoder's write requests into architectural write enables.
module condlogic
    import condlogic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       sample_pend_q;
    logic       cond_ex;
    logic [1:0] flag_write;

    condlogic_condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        flag_write = FlagW & {2{cond_ex_q}};
        flags_d    = flags_q;
        if (flag_write[1]) begin
            flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
        end
        if (flag_write[0]) begin
            flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
        end
        // Sampled against pre-update flags so an instruction never re-evaluates itself.
        cond_ex_d = sample_pend_q ? cond_ex : cond_ex_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q       <= 4'b0000;
            cond_ex_q     <= 1'b0;
            sample_pend_q <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            cond_ex_q     <= cond_ex_d;
            sample_pend_q <= IRWrite;
        end
    end

    // NextPC bypasses the gate so fetch always advances the PC.
    assign PCWrite  = (PCS & cond_ex_q) | NextPC;
    assign RegWrite = RegW & cond_ex_q;
    assign MemWrite = MemW & cond_ex_q;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed table, full condition sweep,
// hand-written multi-cycle corners and randomized instructions against a model.
module tb_condlogic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, IRWrite;
    logic       PCWrite, RegWrite, MemWrite;
    logic [3:0] Flags;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural flags, condition outcome of the
    // current instruction, and whether the next edge closes a decode cycle.
    logic [3:0] m_flags;
    logic       m_ok;
    logic       m_pend;

    condlogic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags)
    );

    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs at negedge, advance model.
    task automatic cycle(input logic irw, input logic [3:0] c, input logic pcs,
                         input logic nxt, input logic regw, input logic memw,
                         input logic [1:0] fw, input logic [3:0] alu,
                         output logic [2:0] outs);
        logic new_ok;
        IRWrite = irw; Cond = c; PCS = pcs; NextPC = nxt;
        RegW = regw; MemW = memw; FlagW = fw; ALUFlags = alu;
        @(negedge clk);
        check("pcwrite", {3'b0, PCWrite}, {3'b0, (pcs & m_ok) | nxt});
        check("regwrite", {3'b0, RegWrite}, {3'b0, regw & m_ok});
        check("memwrite", {3'b0, MemWrite}, {3'b0, memw & m_ok});
        check("flags", Flags, m_flags);
        outs = {PCWrite, RegWrite, MemWrite};
        @(posedge clk);
        new_ok = m_pend ? cond_ref(c, m_flags) : m_ok;
        if (fw[1] && m_ok) m_flags[3:2] = alu[3:2];
        if (fw[0] && m_ok) m_flags[1:0] = alu[1:0];
        m_ok   = new_ok;
        m_pend = irw;
        #1;
    endtask

    task automatic do_reset(input logic pcs, input logic regw, input logic nxt);
        reset = 1'b1; PCS = pcs; RegW = regw; NextPC = nxt;
        MemW = 1'b0; IRWrite = 1'b0; FlagW = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;
        m_flags = 4'b0000; m_ok = 1'b0; m_pend = 1'b0;
    endtask

    task automatic fetch_decode(input logic [3:0] c);
        logic [2:0] o;
        cycle(1'b1, c, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, o);
        cycle(1'b0, c, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, o);
    endtask

    task automatic set_flags(input logic [3:0] f);
        logic [2:0] o;
        fetch_decode(4'b1110);
        cycle(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, f, o);
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [2:0] o;
        logic [3:0] rc;
        tbl[0]  = '{4'b0100, 4'b0000, 1'b1};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0001, 1'b0};
        tbl[3]  = '{4'b0010, 4'b0010, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0011, 1'b1};
        tbl[5]  = '{4'b1000, 4'b0100, 1'b1};
        tbl[6]  = '{4'b1000, 4'b0101, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0110, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0111, 1'b0};
        tbl[9]  = '{4'b0010, 4'b1000, 1'b1};
        tbl[10] = '{4'b0110, 4'b1000, 1'b0};
        tbl[11] = '{4'b0110, 4'b1001, 1'b1};
        tbl[12] = '{4'b1001, 4'b1010, 1'b1};
        tbl[13] = '{4'b1000, 4'b1011, 1'b1};
        tbl[14] = '{4'b0000, 4'b1100, 1'b1};
        tbl[15] = '{4'b0100, 4'b1100, 1'b0};
        tbl[16] = '{4'b1000, 4'b1101, 1'b1};
        tbl[17] = '{4'b0000, 4'b1101, 1'b0};
        tbl[18] = '{4'b0000, 4'b1110, 1'b1};
        tbl[19] = '{4'b0100, 4'b1111, 1'b1};

        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; IRWrite = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_flags = 4'b0000; m_ok = 1'b0; m_pend = 1'b0;

        // Reset state: writes blocked, PC follows NextPC only.
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'h0, o);
        check("rst_outs", {1'b0, o}, 4'b0000);
        check("rst_flags", Flags, 4'b0000);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'h0, o);
        check("rst_nextpc", {1'b0, o}, 4'b0100);

        // AL instruction writes flags and register.
        fetch_decode(4'b1110);
        cycle(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'b1001, o);
        check("al_regwrite", {1'b0, o}, 4'b0010);
        check("al_flags", Flags, 4'b1001);

        // NE with Z=1: everything suppressed.
        set_flags(4'b0100);
        fetch_decode(4'b0001);
        cycle(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 4'b1011, o);
        check("ne_outs", {1'b0, o}, 4'b0000);
        check("ne_flags", Flags, 4'b0100);

        // Failing EQ with two write-back cycles: own flag write must not re-enable it.
        set_flags(4'b0000);
        fetch_decode(4'b0000);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'b0100, o);
        check("muls_rw1", {1'b0, o}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, o);
        check("muls_rw2", {1'b0, o}, 4'b0000);
        check("muls_flags", Flags, 4'b0000);

        // Only N,Z update; C,V kept.
        set_flags(4'b1000);
        fetch_decode(4'b1011);
        cycle(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0111, o);
        check("nz_only", Flags, 4'b0100);
        set_flags(4'b1111);
        fetch_decode(4'b1110);
        cycle(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, o);
        check("cv_only", Flags, 4'b1100);

        // Sample and flag write in the same cycle: sample sees old flags.
        set_flags(4'b0000);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, o);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0100, o);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, o);
        check("same_cyc_rw", {1'b0, o}, 4'b0000);
        check("same_cyc_flags", Flags, 4'b0100);

        // Back-to-back IRWrite: last sample wins.
        set_flags(4'b0000);
        cycle(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, o);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, o);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, o);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, o);
        check("last_wins", {1'b0, o}, 4'b0000);

        // Reset mid-instruction.
        set_flags(4'b1010);
        fetch_decode(4'b1110);
        do_reset(1'b1, 1'b1, 1'b0);
        check("midrst_flags", Flags, 4'b0000);
        cycle(1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, o);
        check("midrst_outs", {1'b0, o}, 4'b0000);
        cycle(1'b0, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, o);
        check("midrst_nextpc", {1'b0, o}, 4'b0100);

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            set_flags(tbl[i].flags);
            fetch_decode(tbl[i].cond);
            cycle(1'b0, tbl[i].cond, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, o);
            check($sformatf("tbl%0d", i), {3'b0, o[1]}, {3'b0, tbl[i].exp});
        end

        // Full sweep against the model.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                set_flags(4'(f));
                fetch_decode(4'(c));
                cycle(1'b0, 4'(c), 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'h0, o);
            end
        end

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                rc = 4'($urandom);
                if ($urandom_range(0, 4) == 0)
                    cycle(1'b1, 4'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, o);
                fetch_decode(rc);
                for (int e = 0; e < int'($urandom_range(1, 3)); e++) begin
                    cycle(1'b0, rc, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
                          2'($urandom), 4'($urandom), o);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/condlogic.md
# condlogic

Condition stage of the multicycle controller: sits directly downstream of the instruction decoder and main FSM. It holds the NZCV flag register and evaluates the instruction's 4-bit condition field once per instruction. It then gates the decoder's raw write requests (PCS, RegW, MemW, FlagW) into the architectural write enables used by the datapath. NextPC passes through ungated, so the unconditional PC increment during fetch is never suppressed.

## Interface
Parameters: none.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Cond  in  4  Instr[31:28] of the instruction register
- ALUFlags  in  4  {N,Z,C,V} from ALU/multiplier, valid in the cycle FlagW is asserted
- FlagW  in  2  from decoder: [1] requests N,Z update, [0] requests C,V update
- PCS  in  1  from decoder: instruction writes PC (branch or Rd=PC)
- NextPC  in  1  from FSM: unconditional PC increment (fetch)
- RegW  in  1  from FSM: register-file write request
- MemW  in  1  from FSM: memory write request
- IRWrite  in  1  from FSM: instruction register loads this cycle
- PCWrite  out  1  PC enable
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data memory write enable
- Flags  out  4  current {N,Z,C,V} register (carry-in for ADC/SBC, debug)

## Operation
- Registers: Flags[3:0], CondExReg, SamplePend.
- SamplePend <= IRWrite every cycle. It is high in the decode cycle, the first cycle with a stable Cond.
- When SamplePend=1: CondExReg <= condcheck(Cond, Flags), evaluated against the current, pre-update Flags. Otherwise CondExReg holds.
  - The sample is taken once per instruction.
  - Flags written by the instruction itself (e.g. MULS before its second write-back cycle) never re-evaluate its condition.
- condcheck encodings:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as AL (1)
- FlagWrite[1:0] = FlagW & {2{CondExReg}}.
  - FlagWrite[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent.
- Combinational outputs:
  - PCWrite = (PCS & CondExReg) | NextPC
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
- reset=1 at an edge: Flags <= 0000, CondExReg <= 0, SamplePend <= 0. It has priority over every load.
- Reset values: Flags=0000. RegWrite and MemWrite are 0 for any RegW/MemW. PCWrite = NextPC.

## Timing
- Cycle F (IRWrite=1) → cycle D (SamplePend=1, CondExReg sampled at end of D).
- From cycle E onward: CondExReg valid; gated outputs are valid in the same cycle as their request (zero added latency).
- Flags update visible the cycle after FlagW assertion.
- SamplePend and FlagWrite in the same cycle: the sample uses the old Flags, and the update still happens.
- IRWrite on consecutive cycles: each following cycle re-samples; the last sample wins.
- Between instructions, CondExReg keeps the previous instruction's value until the next D cycle. The FSM guarantees PCS/RegW/MemW/FlagW are low in F and D.
- Reset asserted mid-instruction: all state is cleared at that edge. A pending sample is discarded, and writes are blocked until the next F/D pair.

## Structure
- Shared controller package:
  - condition-code localparams COND_EQ … COND_AL, COND_NV
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module condcheck: purely combinational, inputs Cond[3:0] and Flags[3:0], output CondEx.
- Top level holds the three registers and the output gating.

## Test plan
- Reset, then F/D with Cond=1110, then RegW=1, FlagW=11, ALUFlags=1001 → RegWrite=1; Flags=1001 next cycle.
- Flags=0100 (Z=1), Cond=0001 (NE), then RegW=1, MemW=1, PCS=1, FlagW=11, NextPC=0 → RegWrite=MemWrite=PCWrite=0; Flags stay 0100.
- Flags=0000, Cond=0000 (EQ), FlagW=11 with ALUFlags=0100 in E, then second write-back RegW=1 (MULS) → RegWrite=0 in both cycles, Flags unchanged.
- Flags=1000, Cond=1011 (LT) true; FlagW=10 with ALUFlags=0111 → Flags=0111? No: only N,Z update → Flags=0100 (C,V preserved at 00).
- Sweep all 16 Cond against all 16 Flags values in the D cycle → CondExReg matches the encoding list; 1111 yields 1.
- Reset asserted in E with PCS=1, RegW=1 → next cycle Flags=0000, RegWrite=0, PCWrite=NextPC.
